// File: rtl/conv_mac_array.sv
// conv_mac_array: CH parallel signed multiply-accumulate channels over K-tap
// windows, with per-channel bias, optional ReLU and a registered result per window.
module conv_mac_array #(
  parameter int CH         = 16,
  parameter int K          = 3,
  parameter int DW         = 8,
  parameter int WW         = 8,
  parameter int BW         = 8,
  parameter int ACC_W      = 30,
  parameter int FRAC_SHIFT = 9,
  parameter int NUM_WIN    = 1260,
  parameter int RELU       = 0,
  parameter int CW         = $clog2(NUM_WIN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic signed [DW-1:0]   data_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WW*CH-1:0]       w_in,
  input  logic                   b_en,
  input  logic signed [BW-1:0]   b_in,
  output logic [ACC_W*CH-1:0]    dataout,
  output logic                   out_valid,
  output logic [CW-1:0]          conv_time,
  output logic                   conv_done
);

  localparam int TW = (K > 1) ? $clog2(K) : 1;
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = DW + WW;

  logic [TW-1:0] tap;
  logic [IW-1:0] b_idx;
  logic          accept;
  logic          last_tap;

  // Refuse samples once the layer's window budget is used up.
  assign conv_done = (conv_time == CW'(NUM_WIN));
  assign in_ready  = !conv_done;
  assign accept    = in_valid & in_ready & ~clr;
  assign last_tap  = (tap == TW'(K - 1));

  // Tap position, completed-window count and the one-cycle result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap       <= '0;
      conv_time <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      tap       <= '0;
      conv_time <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept & last_tap;
      if (accept) begin
        if (last_tap) begin
          tap       <= '0;
          conv_time <= conv_time + CW'(1);
        end else begin
          tap <= tap + TW'(1);
        end
      end
    end
  end

  // Bias write pointer walks the channels and wraps back to channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_idx <= '0;
    end else if (clr) begin
      b_idx <= '0;
    end else if (b_en) begin
      b_idx <= (b_idx == IW'(CH - 1)) ? '0 : b_idx + IW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [PW-1:0]    prod;
      logic signed [ACC_W-1:0] p;
      logic signed [ACC_W-1:0] bias_sh;
      logic signed [ACC_W-1:0] r;
      logic signed [ACC_W-1:0] res;
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] dout;
      logic signed [BW-1:0]    bias;

      // Full-precision product, then scaled and wrapped into the accumulator width.
      assign prod    = PW'(data_in) * PW'($signed(w_in[WW*gi +: WW]));
      assign p       = ACC_W'(prod) <<< FRAC_SHIFT;
      assign bias_sh = ACC_W'(bias) <<< FRAC_SHIFT;
      assign r       = acc + p + bias_sh;
      assign res     = ((RELU != 0) && (r < 0)) ? '0 : r;
      assign dataout[ACC_W*gi +: ACC_W] = dout;

      // Tap 0 overwrites the accumulator so no separate clear cycle is needed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc <= '0;
        end else if (clr) begin
          acc <= '0;
        end else if (accept) begin
          acc <= (tap == '0) ? p : acc + p;
        end
      end

      // Bias survives clr so a layer's biases can be loaded before clearing.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bias <= '0;
        end else if (b_en && !clr && (b_idx == IW'(gi))) begin
          bias <= b_in;
        end
      end

      // Result register holds until the next window completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout <= '0;
        end else if (accept && last_tap) begin
          dout <= res;
        end
      end
    end
  endgenerate

endmodule
